// File: rtl/pc_sequencer.sv
// pc_sequencer -- next-PC controller for the monocycle MIPS core.
//
// Owns the program-counter register and picks the next PC on every accepted
// fetch (handshake = fetch_valid_o & fetch_ready_i). The same choice is
// exported as a 2-bit select so the external 3:1 next-PC mux always agrees
// with the internal PC update. Redirects that arrive while instruction memory
// is stalled are held in a one-entry pending latch until the next handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   fetch_ready_i         instruction memory accepts pc_o this cycle
//   branch_taken_i        branch taken, branch_target_i valid
//   branch_target_i       branch destination
//   jump_i                jump requested, jump_target_i valid
//   jump_target_i         jump destination
//   halt_i                stop fetching after the current cycle
//   fetch_valid_o         pc_o is a valid fetch request (registered)
//   pc_o                  current program counter (registered)
//   next_pc_o             value pc_o takes on the next handshake (comb)
//   sel_o                 next-PC mux select: 00 PC+4, 01 branch, 10 jump (comb)
//   redirect_pending_o    a redirect is latched awaiting a handshake (registered)
//   align_err_o           sticky: a used/latched target had nonzero [1:0]
//   fetch_count_o         completed handshakes since reset, wrapping
module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             halt_i,
  output logic             fetch_valid_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] next_pc_o,
  output logic [1:0]       sel_o,
  output logic             redirect_pending_o,
  output logic             align_err_o,
  output logic [31:0]      fetch_count_o
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;

  state_e           state_q, state_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_q, pend_d;
  logic             pend_jump_q, pend_jump_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             align_err_q, align_err_d;
  logic [31:0]      fetch_count_q, fetch_count_d;

  logic [WIDTH-1:0] jump_tgt, branch_tgt, live_tgt, pc_plus4;
  logic             live_redirect, live_bad, handshake, may_overwrite;
  logic [WIDTH-1:0] next_pc;
  logic [1:0]       sel;

  // Targets always have their byte-offset bits cleared before use.
  assign jump_tgt   = {jump_target_i[WIDTH-1:2], 2'b00};
  assign branch_tgt = {branch_target_i[WIDTH-1:2], 2'b00};
  assign pc_plus4   = pc_q + WIDTH'(4);

  // The live redirect that wins priority (jump over branch).
  assign live_redirect = jump_i | branch_taken_i;
  assign live_tgt      = jump_i ? jump_tgt : branch_tgt;
  assign live_bad      = jump_i ? (jump_target_i[1:0] != 2'b00)
                                : (branch_taken_i && (branch_target_i[1:0] != 2'b00));
  assign handshake     = fetch_valid_q & fetch_ready_i;

  // A latched jump may only be replaced by another jump; a latched branch by anything.
  assign may_overwrite = !pend_q || jump_i || !pend_jump_q;

  // Next-PC selection: live jump, live branch, pending jump, pending branch, PC+4.
  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_plus4;
    if (jump_i) begin
      sel     = SEL_JMP;
      next_pc = jump_tgt;
    end else if (branch_taken_i) begin
      sel     = SEL_BR;
      next_pc = branch_tgt;
    end else if (pend_q) begin
      sel     = pend_jump_q ? SEL_JMP : SEL_BR;
      next_pc = pend_target_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_jump_d   = pend_jump_q;
    pend_target_d = pend_target_q;
    align_err_d   = align_err_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      S_BOOT: begin
        state_d       = S_FETCH;
        fetch_valid_d = 1'b1;
      end
      S_FETCH: begin
        if (handshake) begin
          pc_d          = next_pc;
          fetch_count_d = fetch_count_q + 32'd1;
          pend_d        = 1'b0;
          if (live_redirect && live_bad) align_err_d = 1'b1;
        end else if (live_redirect && may_overwrite) begin
          pend_d        = 1'b1;
          pend_jump_d   = jump_i;
          pend_target_d = live_tgt;
          if (live_bad) align_err_d = 1'b1;
        end
        if (halt_i) begin
          state_d       = S_HALTED;
          fetch_valid_d = 1'b0;
        end
      end
      S_HALTED: begin
        // Everything frozen; only reset leaves this state.
      end
      default: begin
        state_d       = S_BOOT;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      fetch_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_jump_q   <= 1'b0;
      pend_target_q <= '0;
      align_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_jump_q   <= pend_jump_d;
      pend_target_q <= pend_target_d;
      align_err_q   <= align_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_valid_o      = fetch_valid_q;
  assign pc_o               = pc_q;
  assign next_pc_o          = next_pc;
  assign sel_o              = sel;
  assign redirect_pending_o = pend_q;
  assign align_err_o        = align_err_q;
  assign fetch_count_o      = fetch_count_q;

endmodule
